mac3_sched: RTL

- Sequencing controller for the 4-stage, 3-product pipelined MAC (one kernel row of 3 taps per beat).
- Counts beats per output and number of outputs, and drives the MAC's global enable, accumulate flag and channel tag.
- Tracks which pipeline stage holds a finished sum, presents it to the output writer with valid/ready, and drains the pipeline with bubble beats at job end.
- Operand and partial-sum data run straight from the operand source to the MAC. This block only gates and sequences them.

---
 rtl/mac3_sched.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/mac3_sched.sv
// mac3_sched: sequencing controller for the 4-stage, 3-product pipelined MAC.
//
// Purpose:
//   Issues operand beats (one kernel row of 3 taps per beat) from the operand
//   source into the MAC and counts K beats per output over N outputs. It drives
//   the MAC enable, accumulate flag and channel tag. A shadow pipe follows the
//   MAC stages so the block knows when stage 4 holds a finished sum. That sum is
//   presented with valid/ready. At job end the MAC is flushed with bubble beats.
//   Operand data never passes through this block.
//
// Ports:
//   clk, arst_n_in           clock, asynchronous active-low reset
//   start                    one-cycle job start pulse (honoured only in IDLE)
//   cfg_beats/outputs/ch_base  job configuration, latched on start
//   op_valid / op_ready      operand source handshake
//   mac_input_valid          MAC pipeline enable (real beat or bubble)
//   mac_accumulate_internal  0 on first beat of an output and on bubbles
//   mac_ch_out_in            channel tag fed into the MAC with each beat
//   res_valid / res_ready    finished-sum handshake to the output writer
//   res_ch_out               tag of the presented result
//   busy, done               job active / one-cycle completion pulse
module mac3_sched #(
    parameter int CNT_WIDTH  = 16,
    parameter int PIPE_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 arst_n_in,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] cfg_beats,
    input  logic [CNT_WIDTH-1:0] cfg_outputs,
    input  logic [31:0]          cfg_ch_base,
    input  logic                 op_valid,
    output logic                 op_ready,
    output logic                 mac_input_valid,
    output logic                 mac_accumulate_internal,
    output logic [31:0]          mac_ch_out_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_ch_out,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_k;
    logic [CNT_WIDTH-1:0]   r_n;
    logic [CNT_WIDTH-1:0]   r_beats;
    logic [CNT_WIDTH-1:0]   r_outputs;
    logic [CNT_WIDTH-1:0]   r_res_cnt;
    logic [31:0]            r_ch_base;
    logic [PIPE_DEPTH-1:0]  r_sh_valid;
    logic [PIPE_DEPTH-1:0]  r_sh_last;
    logic [31:0]            r_sh_tag [PIPE_DEPTH];
    logic                   r_consumed;

    logic                   w_start_job;
    logic                   w_res_valid;
    logic                   w_res_stall;
    logic                   w_accept;
    logic                   w_pending;
    logic                   w_op_ready;
    logic                   w_fire;
    logic                   w_bubble;
    logic                   w_shift;
    logic                   w_last_beat;
    logic                   w_last_output;
    logic [31:0]            w_tag;
    logic [CNT_WIDTH-1:0]   w_beats_eff;

    // A zero beat count is treated as one beat per output.
    assign w_beats_eff   = (cfg_beats == CNT_ZERO) ? CNT_ONE : cfg_beats;
    assign w_start_job   = (r_state == ST_IDLE) && start;

    // Stage 4 holds a finished sum only if it is the last beat of an output
    // and the writer has not already taken it.
    assign w_res_valid   = r_sh_valid[PIPE_DEPTH-1] && r_sh_last[PIPE_DEPTH-1] && !r_consumed;
    assign w_res_stall   = w_res_valid && !res_ready;
    assign w_accept      = w_res_valid && res_ready;
    // Results still travelling through the stages ahead of stage 4.
    assign w_pending     = |(r_sh_valid[PIPE_DEPTH-2:0] & r_sh_last[PIPE_DEPTH-2:0]);

    assign w_op_ready    = (r_state == ST_RUN) && !w_res_stall;
    assign w_fire        = op_valid && w_op_ready;
    assign w_bubble      = (r_state == ST_DRAIN) && !w_res_stall && w_pending;
    // Every MAC enable advances the MAC and the shadow pipe together.
    assign w_shift       = w_fire || w_bubble;
    assign w_last_beat   = (r_k == (r_beats - CNT_ONE));
    assign w_last_output = (r_n == (r_outputs - CNT_ONE));
    assign w_tag         = r_ch_base + 32'(r_n);

    assign op_ready                = w_op_ready;
    assign mac_input_valid         = w_shift;
    assign mac_accumulate_internal = (r_state == ST_RUN) && (r_k != CNT_ZERO);
    assign mac_ch_out_in           = (r_state == ST_RUN) ? w_tag : 32'd0;
    assign res_valid               = w_res_valid;
    assign res_ch_out              = w_res_valid ? r_sh_tag[PIPE_DEPTH-1] : 32'd0;
    assign busy                    = (r_state != ST_IDLE);
    assign done                    = (r_state == ST_DONE);

    // Next-state decode for the job sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (cfg_outputs == CNT_ZERO) ? ST_DONE : ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_fire && w_last_beat && w_last_output) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Leave on the accept that makes the result count reach N.
                if (w_accept && (r_res_cnt == (r_outputs - CNT_ONE))) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Job configuration latched on an accepted start.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_beats   <= CNT_ONE;
            r_outputs <= CNT_ZERO;
            r_ch_base <= 32'd0;
        end else if (w_start_job) begin
            r_beats   <= w_beats_eff;
            r_outputs <= cfg_outputs;
            r_ch_base <= cfg_ch_base;
        end
    end

    // Beat and output indices, advanced only by fired beats.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_k <= CNT_ZERO;
            r_n <= CNT_ZERO;
        end else if (w_start_job) begin
            r_k <= CNT_ZERO;
            r_n <= CNT_ZERO;
        end else if (w_fire) begin
            if (w_last_beat) begin
                r_k <= CNT_ZERO;
                r_n <= r_n + CNT_ONE;
            end else begin
                r_k <= r_k + CNT_ONE;
            end
        end
    end

    // Count of results accepted by the output writer.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_res_cnt <= CNT_ZERO;
        end else if (w_start_job) begin
            r_res_cnt <= CNT_ZERO;
        end else if (w_accept) begin
            r_res_cnt <= r_res_cnt + CNT_ONE;
        end
    end

    // Consumed flag: a shift brings a new entry into stage 4, which wins over
    // an accept in the same cycle.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_consumed <= 1'b0;
        end else if (w_start_job || w_shift) begin
            r_consumed <= 1'b0;
        end else if (w_accept) begin
            r_consumed <= 1'b1;
        end
    end

    // Shadow pipe mirroring the MAC stages; bubbles enter as empty entries.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            r_sh_valid <= {PIPE_DEPTH{1'b0}};
            r_sh_last  <= {PIPE_DEPTH{1'b0}};
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_sh_tag[i] <= 32'd0;
            end
        end else if (w_start_job) begin
            r_sh_valid <= {PIPE_DEPTH{1'b0}};
            r_sh_last  <= {PIPE_DEPTH{1'b0}};
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_sh_tag[i] <= 32'd0;
            end
        end else if (w_shift) begin
            r_sh_valid <= {r_sh_valid[PIPE_DEPTH-2:0], w_fire};
            r_sh_last  <= {r_sh_last[PIPE_DEPTH-2:0], w_fire && w_last_beat};
            r_sh_tag[0] <= w_fire ? w_tag : 32'd0;
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                r_sh_tag[i] <= r_sh_tag[i-1];
            end
        end
    end

endmodule
